// File: rtl/nf_arb_pkg.sv
// -----------------------------------------------------------------------------
// nf_arb_pkg
// Shared types and constants for the core-side request arbiter (nf_cc_req_arb)
// and its starvation counter.
//   arb_state_t   : grant FSM state encoding
//   GRANT_*       : one-hot encodings driven on the arbiter's grant output
//   STARVE_CNT_W  : width of the instruction-starvation counter
// -----------------------------------------------------------------------------
package nf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage : nf_arb_pkg

// File: rtl/nf_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// nf_arb_starve_cnt
// Saturating up-counter that tracks how many data grants in a row were issued
// while the instruction port was kept waiting.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset (clears the count)
//   inc    in  count one more data grant (ignored once saturated)
//   clr    in  clear the count (wins over inc)
//   lim    in  saturation limit
//   sat    out count has reached lim
// -----------------------------------------------------------------------------
module nf_arb_starve_cnt
  import nf_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  input  logic [STARVE_CNT_W-1:0] lim,
  output logic                    sat
);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < lim)) begin
      cnt_d = cnt_q + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == lim);

endmodule : nf_arb_starve_cnt

// File: rtl/nf_cc_req_arb.sv
// -----------------------------------------------------------------------------
// nf_cc_req_arb
// Shares the single core-side request/ack port towards nf_ahb_top between the
// CPU instruction-fetch port (_i) and the data-memory port (_dm).
// Data has priority; after starve_lim consecutive data grants taken while the
// instruction port was waiting, the instruction port wins the next tie.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate on this cycle's requests (bubble slot)
// GNT_I | instruction port owns the shared port until req_ack_cc
// GNT_D | data port owns the shared port until req_ack_cc
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   addr_i/wd_i/we_i/size_i/req_i      instruction requester payload/request
//   req_ack_i, rd_i                    instruction ack pulse, read data
//   addr_dm/wd_dm/we_dm/size_dm/req_dm data requester payload/request
//   req_ack_dm, rd_dm                  data ack pulse, read data
//   addr_cc/wd_cc/we_cc/size_cc/req_cc shared port towards the interconnect
//   req_ack_cc, rd_cc                  shared port ack pulse, read data
//   grant                              one-hot owner (bit0 instr, bit1 data)
// -----------------------------------------------------------------------------
module nf_cc_req_arb
  import nf_arb_pkg::*;
#(
  parameter int unsigned starve_lim = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction requester
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        req_i,
  output logic        req_ack_i,
  output logic [31:0] rd_i,
  // data requester
  input  logic [31:0] addr_dm,
  input  logic [31:0] wd_dm,
  input  logic        we_dm,
  input  logic [1:0]  size_dm,
  input  logic        req_dm,
  output logic        req_ack_dm,
  output logic [31:0] rd_dm,
  // shared port
  output logic [31:0] addr_cc,
  output logic [31:0] wd_cc,
  output logic        we_cc,
  output logic [1:0]  size_cc,
  output logic        req_cc,
  input  logic        req_ack_cc,
  input  logic [31:0] rd_cc,
  // current owner
  output logic [1:0]  grant
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM_V = STARVE_CNT_W'(starve_lim);

  arb_state_t state_q;
  arb_state_t state_d;

  logic cnt_inc;
  logic cnt_clr;
  logic starve_sat;

  nf_arb_starve_cnt u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .lim   (STARVE_LIM_V),
    .sat   (starve_sat)
  );

  // Next state and counter control. Grants are never preempted; a requester
  // dropping req while owning the port does not release it early.
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_dm && !(req_i && starve_sat)) begin
          state_d = GNT_D;
          // only a data grant that actually overtakes a waiting fetch counts
          cnt_inc = req_i;
        end else if (req_i) begin
          state_d = GNT_I;
          cnt_clr = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (req_ack_cc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shared-port mux and ack routing, decoded from the registered state so the
  // payload is driven from the cycle after arbitration. An ack seen in IDLE
  // matches no owner and is dropped here.
  always_comb begin
    addr_cc    = '0;
    wd_cc      = '0;
    we_cc      = 1'b0;
    size_cc    = '0;
    req_cc     = 1'b0;
    grant      = GRANT_NONE;
    req_ack_i  = 1'b0;
    req_ack_dm = 1'b0;
    unique case (state_q)
      GNT_I: begin
        addr_cc   = addr_i;
        wd_cc     = wd_i;
        we_cc     = we_i;
        size_cc   = size_i;
        req_cc    = 1'b1;
        grant     = GRANT_I;
        req_ack_i = req_ack_cc;
      end
      GNT_D: begin
        addr_cc    = addr_dm;
        wd_cc      = wd_dm;
        we_cc      = we_dm;
        size_cc    = size_dm;
        req_cc     = 1'b1;
        grant      = GRANT_D;
        req_ack_dm = req_ack_cc;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each requester qualifies it with its own ack.
  assign rd_i  = rd_cc;
  assign rd_dm = rd_cc;

endmodule : nf_cc_req_arb

// File: tb/tb_nf_cc_req_arb.sv
module tb_nf_cc_req_arb;

  logic        clk;
  logic        reset;
  logic [31:0] addr_i, wd_i, addr_dm, wd_dm, rd_cc;
  logic        we_i, req_i, we_dm, req_dm, req_ack_cc;
  logic [1:0]  size_i, size_dm;
  logic        req_ack_i, req_ack_dm, we_cc, req_cc;
  logic [31:0] rd_i, rd_dm, addr_cc, wd_cc;
  logic [1:0]  size_cc, grant;

  nf_cc_req_arb dut (
    .clk        (clk),
    .reset      (reset),
    .addr_i     (addr_i),
    .wd_i       (wd_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .req_i      (req_i),
    .req_ack_i  (req_ack_i),
    .rd_i       (rd_i),
    .addr_dm    (addr_dm),
    .wd_dm      (wd_dm),
    .we_dm      (we_dm),
    .size_dm    (size_dm),
    .req_dm     (req_dm),
    .req_ack_dm (req_ack_dm),
    .rd_dm      (rd_dm),
    .addr_cc    (addr_cc),
    .wd_cc      (wd_cc),
    .we_cc      (we_cc),
    .size_cc    (size_cc),
    .req_cc     (req_cc),
    .req_ack_cc (req_ack_cc),
    .rd_cc      (rd_cc),
    .grant      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [1:0]  size;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [1:0] g, input logic [31:0] a,
                               input logic [31:0] w, input logic we, input logic [1:0] s);
    exp_t e;
    e.grant = g; e.addr = a; e.wd = w; e.we = we; e.size = s;
    q.push_back(e);
  endfunction

  task automatic set_dm(input logic [31:0] a, input logic [31:0] w, input logic we,
                        input logic [1:0] s);
    addr_dm = a; wd_dm = w; we_dm = we; size_dm = s;
  endtask

  task automatic set_i(input logic [31:0] a, input logic [31:0] w, input logic we,
                       input logic [1:0] s);
    addr_i = a; wd_i = w; we_i = we; size_i = s;
  endtask

  task automatic all_idle(input string tag);
    chk({tag, "_req_cc"}, req_cc, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ack_i"}, req_ack_i, 0);
    chk({tag, "_ack_dm"}, req_ack_dm, 0);
    chk({tag, "_addr_cc"}, addr_cc, 0);
    chk({tag, "_wd_cc"}, wd_cc, 0);
    chk({tag, "_we_cc"}, we_cc, 0);
    chk({tag, "_size_cc"}, size_cc, 0);
  endtask

  // Requests were driven just after an edge; the arbiter must own the shared
  // port exactly one edge later, showing the scoreboard's next expected owner.
  task automatic begin_xfer(input string tag, output exp_t e);
    int n;
    n = 0;
    while (req_cc !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_sb_nonempty"}, (q.size() > 0) ? 32'd1 : 32'd0, 1);
    if (q.size() > 0) e = q.pop_front();
    else e = '{grant: 2'b11, addr: '1, wd: '1, we: 1'b1, size: 2'b11};
    chk({tag, "_grant"}, grant, e.grant);
    chk({tag, "_addr_cc"}, addr_cc, e.addr);
    chk({tag, "_wd_cc"}, wd_cc, e.wd);
    chk({tag, "_we_cc"}, we_cc, e.we);
    chk({tag, "_size_cc"}, size_cc, e.size);
  endtask

  // Slave answers after lat further cycles with a one-cycle ack; the ack must
  // reach only the owner, and the following cycle is the IDLE bubble.
  task automatic end_xfer(input string tag, input int lat, input bit drop_early,
                          input exp_t e);
    logic [31:0] rd;
    if (drop_early) begin
      if (e.grant[0]) req_i = 1'b0;
      if (e.grant[1]) req_dm = 1'b0;
    end
    repeat (lat) step();
    chk({tag, "_grant_hold"}, grant, e.grant);
    chk({tag, "_req_cc_hold"}, req_cc, 1);
    rd = $urandom;
    rd_cc = rd;
    req_ack_cc = 1'b1;
    #1;
    chk({tag, "_ack_i"}, req_ack_i, e.grant[0]);
    chk({tag, "_ack_dm"}, req_ack_dm, e.grant[1]);
    chk({tag, "_rd_i"}, rd_i, rd);
    chk({tag, "_rd_dm"}, rd_dm, rd);
    step();
    req_ack_cc = 1'b0;
    #1;
    chk({tag, "_bubble_grant"}, grant, 0);
    chk({tag, "_bubble_req"}, req_cc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    req_i = 1'b0; req_dm = 1'b0; req_ack_cc = 1'b0; rd_cc = '0;
    set_i('0, '0, 1'b0, 2'd0);
    set_dm('0, '0, 1'b0, 2'd0);
    step();
    step();
    all_idle("reset");
    reset = 1'b0;
    step();
    all_idle("post_reset");

    // single fetch, slave latency 2
    set_i(32'h100, 32'h0, 1'b0, 2'd2);
    req_i = 1'b1;
    push(2'b01, 32'h100, 32'h0, 1'b0, 2'd2);
    begin_xfer("fetch", e);
    end_xfer("fetch", 2, 1'b0, e);
    req_i = 1'b0;
    step();
    all_idle("fetch_done");

    // conflict: data first, instruction after the bubble
    set_i(32'h300, 32'h0, 1'b0, 2'd2);
    set_dm(32'h200, 32'hcafe_0001, 1'b1, 2'd1);
    req_i = 1'b1; req_dm = 1'b1;
    push(2'b10, 32'h200, 32'hcafe_0001, 1'b1, 2'd1);
    push(2'b01, 32'h300, 32'h0, 1'b0, 2'd2);
    begin_xfer("conf_d", e);
    end_xfer("conf_d", 1, 1'b0, e);
    req_dm = 1'b0;
    begin_xfer("conf_i", e);
    end_xfer("conf_i", 0, 1'b0, e);
    req_i = 1'b0;
    step();

    // stray ack in IDLE goes nowhere and does not move the FSM
    req_ack_cc = 1'b1; rd_cc = 32'h5a5a_5a5a;
    #1;
    chk("stray_ack_i", req_ack_i, 0);
    chk("stray_ack_dm", req_ack_dm, 0);
    step();
    req_ack_cc = 1'b0;
    all_idle("stray_after");

    // starvation: two rounds; the second only yields 4 data grants first if
    // the instruction grant cleared the counter
    for (int r = 0; r < 2; r++) begin
      set_i(32'h400 + 32'(r), 32'h0, 1'b0, 2'd2);
      req_i = 1'b1;
      set_dm(32'h1000 + 32'(r * 16), 32'h10 + 32'(r), 1'b1, 2'd2);
      req_dm = 1'b1;
      push(2'b10, addr_dm, wd_dm, 1'b1, 2'd2);
      for (int k = 0; k < 4; k++) begin
        begin_xfer("starve_d", e);
        end_xfer("starve_d", k % 3, 1'b0, e);
        set_dm(32'h1000 + 32'(r * 16 + k + 1), 32'h20 + 32'(k), 1'b0, 2'd0);
        if (k < 3) push(2'b10, addr_dm, wd_dm, 1'b0, 2'd0);
        else push(2'b01, addr_i, wd_i, 1'b0, 2'd2);
      end
      push(2'b10, addr_dm, wd_dm, 1'b0, 2'd0);
      begin_xfer("starve_i", e);
      end_xfer("starve_i", 1, 1'b0, e);
      req_i = 1'b0;
      begin_xfer("starve_tail", e);
      end_xfer("starve_tail", 0, 1'b0, e);
      req_dm = 1'b0;
      step();
    end

    // requester drops req while owning the port: ack still delivered
    set_dm(32'h2000, 32'h77, 1'b1, 2'd0);
    req_dm = 1'b1;
    push(2'b10, 32'h2000, 32'h77, 1'b1, 2'd0);
    begin_xfer("drop", e);
    end_xfer("drop", 2, 1'b1, e);
    step();

    // reset during GNT_D with the counter at its limit
    set_i(32'h500, 32'h0, 1'b0, 2'd2);
    set_dm(32'h3000, 32'h99, 1'b0, 2'd2);
    req_i = 1'b1; req_dm = 1'b1;
    repeat (4) push(2'b10, 32'h3000, 32'h99, 1'b0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      begin_xfer("pre_rst", e);
      end_xfer("pre_rst", 1, 1'b0, e);
    end
    begin_xfer("rst_mid", e);
    reset = 1'b1;
    step();
    all_idle("rst_mid");
    reset = 1'b0;
    q.delete();
    push(2'b10, 32'h3000, 32'h99, 1'b0, 2'd2);
    begin_xfer("post_rst_d", e);
    end_xfer("post_rst_d", 1, 1'b0, e);
    req_dm = 1'b0;
    push(2'b01, 32'h500, 32'h0, 1'b0, 2'd2);
    begin_xfer("post_rst_i", e);
    end_xfer("post_rst_i", 1, 1'b0, e);
    req_i = 1'b0;
    step();
    all_idle("final");
    chk("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nf_cc_req_arb
